// File: rtl/id_ex_skid_pkg.sv
// Shared widths, bubble encoding and state encoding for the id/ex pipeline register.
// State is encoded directly as {skid_v, main_v} so the valid bits fall out of the state flop.
package id_ex_skid_pkg;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int RAW = 5;

    localparam logic [31:0]   NOP_INST      = 32'h0000_0013;
    localparam logic [DW-1:0] ZERO_WORD     = '0;
    localparam logic          WRITE_ENABLE  = 1'b1;
    localparam logic          WRITE_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_e;

    function automatic int bundle_width(input int dw, input int aw, input int raw);
        return 32 + aw + 4 * dw + 1 + raw;
    endfunction

endpackage

// File: rtl/id_ex_skid_entry.sv
// One payload register bank with load enable; cleared only by reset, never by flush.
module id_ex_skid_entry #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] dat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dat_q <= '0;
        end else if (load_i) begin
            dat_q <= d_i;
        end
    end

    assign q_o = dat_q;

endmodule

// File: rtl/id_ex_skid.sv
// Elastic id->ex register with one skid entry; in_ready_o comes straight from a state flop.
// Latency 1 cycle, full throughput; flush/reset drop both entries and the incoming bundle.
module id_ex_skid
    import id_ex_skid_pkg::*;
#(
    parameter int DW  = id_ex_skid_pkg::DW,
    parameter int AW  = id_ex_skid_pkg::AW,
    parameter int RAW = id_ex_skid_pkg::RAW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [31:0]    inst_i,
    input  logic [AW-1:0]  inst_addr_i,
    input  logic [DW-1:0]  op1_i,
    input  logic [DW-1:0]  op2_i,
    input  logic           reg_wen_i,
    input  logic [RAW-1:0] reg_w_addr_i,
    input  logic [DW-1:0]  reg1_rdata_i,
    input  logic [DW-1:0]  reg2_rdata_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [31:0]    inst_o,
    output logic [AW-1:0]  inst_addr_o,
    output logic [DW-1:0]  op1_o,
    output logic [DW-1:0]  op2_o,
    output logic           reg_wen_o,
    output logic [RAW-1:0] reg_w_addr_o,
    output logic [DW-1:0]  reg1_rdata_o,
    output logic [DW-1:0]  reg2_rdata_o
);

    localparam int BW = bundle_width(DW, AW, RAW);

    state_e          state_q;
    logic            main_v;
    logic            skid_v;
    logic            in_fire;
    logic            out_fire;
    logic            main_load;
    logic            skid_load;
    logic            main_from_skid;
    logic [BW-1:0]   in_bus;
    logic [BW-1:0]   main_d;
    logic [BW-1:0]   main_q;
    logic [BW-1:0]   skid_q;

    logic [31:0]     inst_q;
    logic            wen_q;

    assign main_v   = state_q[0];
    assign skid_v   = state_q[1];
    assign in_ready_o  = ~skid_v;
    assign out_valid_o = main_v;
    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    assign in_bus = {inst_i, inst_addr_i, op1_i, op2_i, reg_wen_i, reg_w_addr_i,
                     reg1_rdata_i, reg2_rdata_i};

    always_comb begin
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (!flush_i) begin
            case (state_q)
                ST_EMPTY: main_load = in_fire;
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_ready_i) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_bus;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else if (flush_i) begin
            state_q <= ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (in_fire) state_q <= ST_ONE;
                ST_ONE: begin
                    if (in_fire && !out_ready_i) begin
                        state_q <= ST_FULL;
                    end else if (!in_fire && out_fire) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_FULL: if (out_ready_i) state_q <= ST_ONE;
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    id_ex_skid_entry #(.W(BW)) u_main (
        .clk    (clk),
        .rst    (rst),
        .load_i (main_load),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    id_ex_skid_entry #(.W(BW)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load_i (skid_load),
        .d_i    (in_bus),
        .q_o    (skid_q)
    );

    assign {inst_q, inst_addr_o, op1_o, op2_o, wen_q, reg_w_addr_o,
            reg1_rdata_o, reg2_rdata_o} = main_q;

    // ex must see a harmless bubble whenever nothing is valid
    assign inst_o    = main_v ? inst_q : NOP_INST;
    assign reg_wen_o = main_v ? wen_q  : WRITE_DISABLE;

endmodule
